// File: rtl/traffic_source_if.sv
// Flit handshake between a traffic source (master) and its sink (slave).
// The master presents req/data; the slave answers with ack in the same cycle.
interface traffic_source_if #(
  parameter int SIZE = 8
);
  logic            req;
  logic            ack;
  logic [SIZE-1:0] data;

  modport master (output req, output data, input ack);
  modport slave  (input req, input data, output ack);
endinterface

// File: rtl/traffic_source.sv
// Packet traffic generator: emits packets of FLITS flits (head + body, tail
// marked in the MSB) over a req/ack handshake, with selectable destination
// policy, inter-packet gap, packet budget and a saturating stall counter.
module traffic_source #(
  parameter int ID         = 0,
  parameter int SIZE       = 8,
  parameter int FLITS      = 8,
  parameter int PACKETS    = 1,
  parameter int DEST_MODE  = 0,
  parameter int DEST       = 0,
  parameter int NDEST_BITS = 2,
  parameter int GAP        = 0,
  parameter int SEED       = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  traffic_source_if.master    bus,
  output logic                done,
  output logic [15:0]         pkt_count,
  output logic [31:0]         stall_count
);

  localparam int PW    = SIZE - 1;
  localparam int IDX_W = $clog2(FLITS);
  localparam int GAP_W = $clog2(GAP + 2);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FLITS - 1);
  localparam logic [15:0] SEED_INIT = (SEED[15:0] == 16'd0) ? 16'd1 : SEED[15:0];

  typedef enum logic [1:0] {S_GAP, S_HEAD, S_BODY, S_DONE} state_t;

  state_t                state;
  logic [GAP_W-1:0]      gap_cnt;
  logic [IDX_W-1:0]      flit_idx;
  logic [15:0]           lfsr_q;
  logic [NDEST_BITS-1:0] rr_q;
  logic                  req_q;
  logic [SIZE-1:0]       data_q;
  logic [PW-1:0]         dest_sel;

  // req and data come straight from flops, so ack never reaches them combinationally.
  assign bus.req  = req_q;
  assign bus.data = data_q;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  function automatic logic [SIZE-1:0] head_flit(input logic [PW-1:0] dst);
    return {1'b0, dst};
  endfunction

  function automatic logic [SIZE-1:0] body_flit(input logic [IDX_W-1:0] k);
    logic [31:0] v;
    v = 32'(ID * FLITS) + 32'(k);
    return {(k == LAST_IDX), v[PW-1:0]};
  endfunction

  // Destination for the packet about to start, chosen by the configured policy.
  always_comb begin
    // NOTE: default assignment first so no path leaves dest_sel unassigned (no latch).
    dest_sel = '0;
    case (DEST_MODE)
      1:       dest_sel = PW'(lfsr_q[NDEST_BITS-1:0]);
      2:       dest_sel = PW'(rr_q);
      default: dest_sel = PW'(DEST);
    endcase
  end

  // Packet FSM with registered req/data/done and the two statistics counters.
  always_ff @(posedge clk) begin
    if (!reset) begin
      // NOTE: non-blocking assignments throughout so every register sees pre-edge values.
      state       <= S_GAP;
      gap_cnt     <= GAP_W'(GAP);
      flit_idx    <= '0;
      lfsr_q      <= SEED_INIT;
      rr_q        <= '0;
      req_q       <= 1'b0;
      data_q      <= '0;
      done        <= 1'b0;
      pkt_count   <= '0;
      stall_count <= '0;
    end else begin
      if (req_q && !bus.ack && stall_count != 32'hFFFF_FFFF)
        stall_count <= stall_count + 32'd1;

      case (state)
        S_GAP: begin
          // gap_cnt counts the idle cycles still owed, including this one.
          if (gap_cnt <= GAP_W'(1) && en) begin
            state  <= S_HEAD;
            req_q  <= 1'b1;
            data_q <= head_flit(dest_sel);
            if (DEST_MODE == 2) rr_q <= rr_q + NDEST_BITS'(1);
          end else if (gap_cnt != '0) begin
            gap_cnt <= gap_cnt - GAP_W'(1);
          end
        end

        S_HEAD: begin
          if (bus.ack) begin
            state    <= S_BODY;
            flit_idx <= IDX_W'(1);
            data_q   <= body_flit(IDX_W'(1));
            lfsr_q   <= lfsr_step(lfsr_q);
          end
        end

        S_BODY: begin
          if (bus.ack) begin
            if (flit_idx == LAST_IDX) begin
              pkt_count <= pkt_count + 16'd1;
              flit_idx  <= '0;
              if (PACKETS != 0 && (32'(pkt_count) + 32'd1) == 32'(PACKETS)) begin
                state <= S_DONE;
                req_q <= 1'b0;
                done  <= 1'b1;
              end else if (GAP == 0 && en) begin
                // Back-to-back packet: the head goes out on the very next edge.
                state  <= S_HEAD;
                data_q <= head_flit(dest_sel);
                if (DEST_MODE == 2) rr_q <= rr_q + NDEST_BITS'(1);
              end else begin
                state   <= S_GAP;
                req_q   <= 1'b0;
                gap_cnt <= GAP_W'(GAP);
              end
            end else begin
              flit_idx <= flit_idx + IDX_W'(1);
              data_q   <= body_flit(flit_idx + IDX_W'(1));
            end
          end
        end

        S_DONE: begin
          // Terminal until reset.
        end
      endcase
    end
  end

endmodule

// File: tb/tb_traffic_source.sv
// Directed bench for traffic_source: three configurations covering fixed,
// round-robin and LFSR destinations, stalls, en gating and mid-packet reset.
module tb_traffic_source;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- Instance A: fixed destination, 4 flits, 1 packet
  logic        rst_a = 1'b0, en_a = 1'b0;
  logic        done_a;
  logic [15:0] pkt_a;
  logic [31:0] stall_a;
  traffic_source_if #(.SIZE(8)) bus_a ();
  traffic_source #(.ID(2), .SIZE(8), .FLITS(4), .PACKETS(1), .DEST_MODE(0), .DEST(3),
                   .NDEST_BITS(2), .GAP(0), .SEED(1)) u_a (
    .clk(clk), .reset(rst_a), .en(en_a), .bus(bus_a),
    .done(done_a), .pkt_count(pkt_a), .stall_count(stall_a));

  // ---------------- Instance B: round-robin, 2 flits, 5 packets, gap 2
  logic        rst_b = 1'b0, en_b = 1'b0;
  logic        done_b;
  logic [15:0] pkt_b;
  logic [31:0] stall_b;
  traffic_source_if #(.SIZE(8)) bus_b ();
  traffic_source #(.ID(0), .SIZE(8), .FLITS(2), .PACKETS(5), .DEST_MODE(2), .DEST(0),
                   .NDEST_BITS(2), .GAP(2), .SEED(1)) u_b (
    .clk(clk), .reset(rst_b), .en(en_b), .bus(bus_b),
    .done(done_b), .pkt_count(pkt_b), .stall_count(stall_b));

  // ---------------- Instance C: LFSR destination, 2 flits, unlimited
  logic        rst_c = 1'b0, en_c = 1'b0;
  logic        done_c;
  logic [15:0] pkt_c;
  logic [31:0] stall_c;
  traffic_source_if #(.SIZE(8)) bus_c ();
  traffic_source #(.ID(5), .SIZE(8), .FLITS(2), .PACKETS(0), .DEST_MODE(1), .DEST(0),
                   .NDEST_BITS(2), .GAP(0), .SEED(1)) u_c (
    .clk(clk), .reset(rst_c), .en(en_c), .bus(bus_c),
    .done(done_c), .pkt_count(pkt_c), .stall_count(stall_c));

  int exp_a [4] = '{32'h03, 32'h09, 32'h0A, 32'h8B};
  int exp_rr [5] = '{0, 1, 2, 3, 0};

  initial begin
    bus_a.ack = 1'b0;
    bus_b.ack = 1'b0;
    bus_c.ack = 1'b0;

    // ---- A1: reset values, then a full packet with ack always high
    en_a = 1'b1;
    bus_a.ack = 1'b1;
    step();
    step();
    check("a_rst_req",   32'(bus_a.req), 32'd0);
    check("a_rst_done",  32'(done_a),    32'd0);
    check("a_rst_pkt",   32'(pkt_a),     32'd0);
    check("a_rst_stall", stall_a,        32'd0);
    rst_a = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("a_req_%0d", i),  32'(bus_a.req),  32'd1);
      check($sformatf("a_data_%0d", i), 32'(bus_a.data), 32'(exp_a[i]));
    end
    step();
    check("a_end_req",   32'(bus_a.req), 32'd0);
    check("a_end_done",  32'(done_a),    32'd1);
    check("a_end_pkt",   32'(pkt_a),     32'd1);
    check("a_end_stall", stall_a,        32'd0);
    step();
    check("a_done_hold", 32'(done_a),    32'd1);
    check("a_done_req",  32'(bus_a.req), 32'd0);

    // ---- A2: ack low for 3 cycles while the head is presented
    rst_a = 1'b0;
    bus_a.ack = 1'b0;
    step();
    rst_a = 1'b1;
    step();
    check("a2_head", 32'(bus_a.data), 32'h03);
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("a2_hold_req_%0d", i),  32'(bus_a.req),  32'd1);
      check($sformatf("a2_hold_data_%0d", i), 32'(bus_a.data), 32'h03);
    end
    bus_a.ack = 1'b1;
    for (int i = 1; i < 4; i++) begin
      step();
      check($sformatf("a2_data_%0d", i), 32'(bus_a.data), 32'(exp_a[i]));
    end
    step();
    check("a2_done",  32'(done_a), 32'd1);
    check("a2_pkt",   32'(pkt_a),  32'd1);
    check("a2_stall", stall_a,     32'd3);

    // ---- A3: reset while flit 2 is presented
    rst_a = 1'b0;
    step();
    rst_a = 1'b1;
    step();
    step();
    step();
    check("a3_flit2", 32'(bus_a.data), 32'h0A);
    rst_a = 1'b0;
    step();
    check("a3_rst_req",   32'(bus_a.req),  32'd0);
    check("a3_rst_data",  32'(bus_a.data), 32'd0);
    check("a3_rst_done",  32'(done_a),     32'd0);
    check("a3_rst_pkt",   32'(pkt_a),      32'd0);
    check("a3_rst_stall", stall_a,         32'd0);
    rst_a = 1'b1;
    step();
    check("a3_first_req",  32'(bus_a.req),  32'd1);
    check("a3_first_head", 32'(bus_a.data), 32'h03);

    // ---- B1: round-robin destinations with a 2-cycle gap
    begin
      int flit_pos = 0;
      int pkt_idx  = 0;
      int idle     = 0;
      int budget   = 0;
      en_b = 1'b1;
      bus_b.ack = 1'b1;
      step();
      rst_b = 1'b1;
      while (!done_b && budget < 100) begin
        step();
        budget++;
        if (bus_b.req) begin
          if (flit_pos == 0) begin
            check($sformatf("b_head_%0d", pkt_idx), 32'(bus_b.data), 32'(exp_rr[pkt_idx % 5]));
            if (pkt_idx > 0) check($sformatf("b_gap_%0d", pkt_idx), 32'(idle), 32'd2);
          end else begin
            check($sformatf("b_body_%0d", pkt_idx), 32'(bus_b.data), 32'h81);
          end
          flit_pos++;
          if (flit_pos == 2) begin
            flit_pos = 0;
            pkt_idx++;
          end
          idle = 0;
        end else begin
          idle++;
        end
      end
      check("b_budget",  32'(budget < 100), 32'd1);
      check("b_packets", 32'(pkt_idx),      32'd5);
      check("b_pkt_cnt", 32'(pkt_b),        32'd5);
      check("b_done",    32'(done_b),       32'd1);
    end

    // ---- B2: en dropped mid-packet
    begin
      int budget = 0;
      rst_b = 1'b0;
      step();
      rst_b = 1'b1;
      while (!bus_b.req && budget < 10) begin
        step();
        budget++;
      end
      check("b2_head_seen", 32'(bus_b.req),  32'd1);
      check("b2_head",      32'(bus_b.data), 32'h00);
      en_b = 1'b0;
      step();
      check("b2_body_req",  32'(bus_b.req),  32'd1);
      check("b2_body",      32'(bus_b.data), 32'h81);
      step();
      check("b2_pkt",       32'(pkt_b),      32'd1);
      for (int i = 0; i < 6; i++) begin
        check($sformatf("b2_blocked_%0d", i), 32'(bus_b.req), 32'd0);
        step();
      end
      check("b2_blocked_end", 32'(bus_b.req), 32'd0);
      en_b = 1'b1;
      step();
      check("b2_resume_req",  32'(bus_b.req),  32'd1);
      check("b2_resume_head", 32'(bus_b.data), 32'h01);
    end

    // ---- C: LFSR destinations, seed 1 -> 1 then 0
    en_c = 1'b1;
    bus_c.ack = 1'b1;
    step();
    rst_c = 1'b1;
    step();
    check("c_head0", 32'(bus_c.data), 32'h01);
    step();
    check("c_body0", 32'(bus_c.data), 32'h8B);
    step();
    check("c_head1_req", 32'(bus_c.req),  32'd1);
    check("c_head1",     32'(bus_c.data), 32'h00);
    check("c_pkt",       32'(pkt_c),      32'd1);
    check("c_not_done",  32'(done_c),     32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/traffic_source.md
TRAFFIC_SOURCE -- requirements
Module: traffic_source

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
  ID, 0, source identifier, carried in body flits
  SIZE, 8, flit width in bits (>=4)
  FLITS, 8, flits per packet including head (>=2)
  PACKETS, 1, packets to send; 0 = unlimited
  DEST_MODE, 0, 0 fixed / 1 LFSR random / 2 round-robin
  DEST, 0, destination in fixed mode
  NDEST_BITS, 2, random/round-robin destinations span 0..2^NDEST_BITS-1 (<=SIZE-1)
  GAP, 0, idle cycles between packets
  SEED, 1, LFSR seed (0 replaced by 1)
REQ-002 Ports SHALL be (name, direction, width, meaning):
  clk  input  1  clock, all logic on rising edge
  reset  input  1  synchronous active-low reset
  en  input  1  permit start of a new packet
  req  output  1  flit valid
  ack  input  1  flit accepted
  data  output  SIZE  flit
  done  output  1  all PACKETS sent
  pkt_count  output  16  packets completed
  stall_count  output  32  cycles with req=1, ack=0

Function
REQ-003 A flit SHALL transfer on a rising edge where req=1 and ack=1; no other edge SHALL transfer a flit.
REQ-004 While req=1 and ack=0, req and data SHALL hold stable.
REQ-005 Flit format: bit SIZE-1 = tail marker, set only on flit FLITS-1.
REQ-006 Head flit (index 0) bits SIZE-2:0 SHALL be the zero-extended destination.
REQ-007 Body flit k (1..FLITS-1) bits SIZE-2:0 SHALL be (ID*FLITS + k) modulo 2^(SIZE-1).
REQ-008 FSM states: GAP, HEAD, BODY, DONE.
REQ-009 GAP: req=0; counts GAP cycles, then enters HEAD at the first cycle where the count is exhausted and en=1; with GAP=0, HEAD is entered directly when en=1.
REQ-010 HEAD: req=1, data=head flit; on transfer go to BODY with flit index 1.
REQ-011 BODY: req=1; each transfer increments the flit index. A transfer of the tail flit SHALL increment pkt_count and then:
  - go to DONE if pkt_count+1 == PACKETS and PACKETS != 0;
  - otherwise go to GAP (or to HEAD on the next edge if GAP=0 and en=1).
REQ-012 DONE: req=0, done=1, terminal until reset.
REQ-013 en=0 SHALL only block entry to HEAD; a packet in progress SHALL complete.
REQ-014 Destination SHALL be latched when HEAD is entered:
  - mode 0: DEST
  - mode 1: lfsr[NDEST_BITS-1:0]
  - mode 2: round-robin counter (starts at 0, +1 per packet, wraps at 2^NDEST_BITS)
REQ-015 LFSR: 16-bit Galois, mask 16'hB400, shift right; advances exactly once per head-flit transfer.
REQ-016 stall_count SHALL increment on every edge with req=1, ack=0, saturating at 2^32-1.
REQ-017 pkt_count SHALL wrap modulo 2^16 when PACKETS=0.
REQ-018 No combinational path from ack to req or data.

Reset
REQ-019 While reset=0 at a rising edge, the block SHALL load:
  - state GAP with gap count GAP, flit index 0
  - req=0, done=0, pkt_count=0, stall_count=0
  - LFSR = SEED (1 if SEED=0), round-robin counter 0
REQ-020 Reset asserted mid-packet SHALL abandon the packet; no further flit of it is presented after reset releases.
REQ-021 The first flit after reset release SHALL be a head flit.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
  - SIZE=8, FLITS=4, PACKETS=1, DEST=3, ID=2, ack=1 always -> data 0x03, 0x09, 0x0A, 0x8B on 4 consecutive edges; then done=1, pkt_count=1, stall_count=0.
  - Same config, ack low for 3 cycles during head -> data held 0x03 throughout, stall_count=3.
  - DEST_MODE=2, NDEST_BITS=2, PACKETS=5, GAP=2 -> head destinations 0, 1, 2, 3, 0; exactly 2 req=0 cycles between packets.
  - DEST_MODE=1, SEED=1, NDEST_BITS=2 -> first two destinations 1, 0 (LFSR 0x0001 -> 0xB400).
  - en=0 asserted mid-packet -> current packet completes; no head flit until en=1.
  - reset=0 asserted on flit 2 of a packet -> all outputs at reset values next edge; first flit after release is a head flit.
